// File: rtl/pic_command_sequencer.sv
// ---------------------------------------------------------------------------
// pic_command_sequencer
// Decodes ICW1-ICW4 initialization words and OCW1-OCW3 operation words
// written by the CPU, holds the resulting configuration, and returns the
// IRR/ISR/IMR read-back byte for the data bus buffer.
// ---------------------------------------------------------------------------
module pic_command_sequencer #(
  parameter logic [7:0] IMR_INIT = 8'h00,
  parameter logic       READ_ISR = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       WR_flag,
  input  logic       RD_flag,
  input  logic       A0,
  input  logic [7:0] Ds_to_Control,
  input  logic [7:0] irr,
  input  logic [7:0] isr,
  output logic [7:0] Ds_from_control,
  output logic [4:0] vector_base,
  output logic       ltim,
  output logic       sngl,
  output logic [7:0] icw3,
  output logic       aeoi,
  output logic [7:0] imr,
  output logic [7:0] ocw2_cmd,
  output logic       ocw2_stb,
  output logic       init_done
);

  typedef enum logic [2:0] {
    ST_ICW1_WAIT = 3'd0,
    ST_ICW2_WAIT = 3'd1,
    ST_ICW3_WAIT = 3'd2,
    ST_ICW4_WAIT = 3'd3,
    ST_READY     = 3'd4
  } state_t;

  state_t     state_q;
  logic       wr_prev_q;
  logic       ic4_q;
  logic       ris_q;
  logic [7:0] ds_q;
  logic [4:0] vector_base_q;
  logic       ltim_q;
  logic       sngl_q;
  logic [7:0] icw3_q;
  logic       aeoi_q;
  logic [7:0] imr_q;
  logic [7:0] ocw2_cmd_q;
  logic       ocw2_stb_q;

  // A command is taken only on the rising edge of the write level, so a
  // long WR_flag pulse yields exactly one command.
  logic wr_event_s;
  logic is_icw1_s;
  assign wr_event_s = WR_flag & ~wr_prev_q;
  assign is_icw1_s  = ~A0 & Ds_to_Control[4];

  // Command sequencer, configuration registers and read-back register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_ICW1_WAIT;
      wr_prev_q     <= 1'b0;
      ic4_q         <= 1'b0;
      ris_q         <= READ_ISR;
      ds_q          <= 8'h00;
      vector_base_q <= 5'd0;
      ltim_q        <= 1'b0;
      sngl_q        <= 1'b0;
      icw3_q        <= 8'h00;
      aeoi_q        <= 1'b0;
      imr_q         <= IMR_INIT;
      ocw2_cmd_q    <= 8'h00;
      ocw2_stb_q    <= 1'b0;
    end else begin
      wr_prev_q  <= WR_flag;
      ocw2_stb_q <= 1'b0;

      if (wr_event_s) begin
        if (is_icw1_s) begin
          // ICW1 restarts initialization from any state.
          ltim_q  <= Ds_to_Control[3];
          sngl_q  <= Ds_to_Control[1];
          ic4_q   <= Ds_to_Control[0];
          imr_q   <= IMR_INIT;
          ris_q   <= READ_ISR;
          aeoi_q  <= 1'b0;
          state_q <= ST_ICW2_WAIT;
        end else begin
          case (state_q)
            ST_ICW1_WAIT: begin
              state_q <= ST_ICW1_WAIT;
            end
            ST_ICW2_WAIT: begin
              if (A0) begin
                vector_base_q <= Ds_to_Control[7:3];
                if (!sngl_q) begin
                  state_q <= ST_ICW3_WAIT;
                end else if (ic4_q) begin
                  state_q <= ST_ICW4_WAIT;
                end else begin
                  state_q <= ST_READY;
                end
              end
            end
            ST_ICW3_WAIT: begin
              if (A0) begin
                icw3_q  <= Ds_to_Control;
                state_q <= ic4_q ? ST_ICW4_WAIT : ST_READY;
              end
            end
            ST_ICW4_WAIT: begin
              if (A0) begin
                aeoi_q  <= Ds_to_Control[1];
                state_q <= ST_READY;
              end
            end
            ST_READY: begin
              if (A0) begin
                imr_q <= Ds_to_Control;
              end else if (!Ds_to_Control[3]) begin
                ocw2_cmd_q <= Ds_to_Control;
                ocw2_stb_q <= 1'b1;
              end else if (Ds_to_Control[1]) begin
                ris_q <= Ds_to_Control[0];
              end
            end
            default: begin
              state_q <= ST_ICW1_WAIT;
            end
          endcase
        end
      end

      // A simultaneous write wins; the read-back byte is left untouched.
      if (RD_flag && !WR_flag) begin
        ds_q <= A0 ? imr_q : (ris_q ? isr : irr);
      end
    end
  end

  assign Ds_from_control = ds_q;
  assign vector_base     = vector_base_q;
  assign ltim            = ltim_q;
  assign sngl            = sngl_q;
  assign icw3            = icw3_q;
  assign aeoi            = aeoi_q;
  assign imr             = imr_q;
  assign ocw2_cmd        = ocw2_cmd_q;
  assign ocw2_stb        = ocw2_stb_q;
  assign init_done       = (state_q == ST_READY);

endmodule
